// File: rtl/inst_fetch_axi.sv
// Instruction fetch unit with an AXI4 read master port.
// Issues single-beat 32-bit reads, holds the returned instruction for decode,
// and handles flushes at any point of a transaction. An AR that is in flight
// is never withdrawn. When a flush arrives, the R beat is drained and dropped.
// Optional feature macro: FETCH_BACK2BACK_EN. When it is defined, a new fetch
// can start directly from HOLD, which saves the idle cycle between fetches.
module inst_fetch_axi (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_ce,
  input  logic        flush,
  input  logic        full,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        inst_err,
  output logic        pc_ack,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic        drop_pending;

  // Single-beat, word-sized INCR reads with a fixed ID.
  assign arid    = 4'd0;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Only one read is ever outstanding, so the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = ^rid;

  // Fetch FSM. Every output is updated in the same block as the state, so all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      inst_valid   <= 1'b0;
      inst_err     <= 1'b0;
      pc_ack       <= 1'b0;
      drop_pending <= 1'b0;
      araddr       <= 32'd0;
      if_inst      <= 32'd0;
      if_pc        <= 32'd0;
      req_pc       <= 32'd0;
    end else begin
      pc_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_ce && !full && !flush) begin
            araddr  <= pc;
            req_pc  <= pc;
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          // The AR must complete once it is issued. A flush seen here is
          // remembered, and the matching R beat is dropped later.
          if (arready) begin
            arvalid      <= 1'b0;
            pc_ack       <= 1'b1;
            rready       <= 1'b1;
            drop_pending <= 1'b0;
            state        <= (flush || drop_pending) ? DROP : DATA;
          end else if (flush) begin
            drop_pending <= 1'b1;
          end
        end
        DATA: begin
          if (rvalid && rlast) begin
            rready <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              if_inst    <= rdata;
              if_pc      <= req_pc;
              inst_err   <= (rresp != 2'b00);
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        HOLD: begin
          if (flush) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
`ifdef FETCH_BACK2BACK_EN
            if (pc_ce && !full) begin
              araddr  <= pc;
              req_pc  <= pc;
              arvalid <= 1'b1;
              state   <= ADDR;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        DROP: begin
          // Drain the orphaned beat. A flush here has nothing left to cancel.
          if (rvalid && rlast) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Self-checking bench for inst_fetch_axi.
// The bench drives directed and random transactions. Expected values come from
// the transaction itself: the fetched pc, the returned data, and the rule that
// any rresp other than OKAY is an error.
module tb_inst_fetch_axi;
  logic        clk = 1'b0;
  logic        rst, pc_ce, flush, full, inst_ready;
  logic [31:0] pc;
  logic        inst_valid, inst_err, pc_ack;
  logic [31:0] if_inst, if_pc;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  inst_fetch_axi dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_ce(pc_ce), .flush(flush), .full(full),
    .inst_ready(inst_ready), .inst_valid(inst_valid), .if_inst(if_inst),
    .if_pc(if_pc), .inst_err(inst_err), .pc_ack(pc_ack), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled, and inputs driven, on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Request a fetch from IDLE. The AR must appear on the next cycle.
  task automatic issue(input logic [31:0] a);
    pc = a; pc_ce = 1'b1;
    cyc();
    pc_ce = 1'b0; pc = $urandom;
    chk("arvalid_up", {31'd0, arvalid}, 1);
    chk("araddr", araddr, a);
  endtask

  // Hold arready low for dly cycles, optionally pulsing flush once, then complete the handshake.
  task automatic handshake(input logic [31:0] a, input int dly, input int flush_at);
    for (int i = 0; i < dly; i++) begin
      flush = (i == flush_at);
      cyc();
      chk("arvalid_hold", {31'd0, arvalid}, 1);
      chk("araddr_stable", araddr, a);
      chk("no_early_ack", {31'd0, pc_ack}, 0);
    end
    flush = 1'b0; arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("pc_ack", {31'd0, pc_ack}, 1);
    chk("arvalid_down", {31'd0, arvalid}, 0);
    chk("rready_up", {31'd0, rready}, 1);
  endtask

  // Wait dly cycles, then deliver a single R beat. The beat can carry a flush in the same cycle.
  task automatic rbeat(input int dly, input logic [31:0] d, input logic [1:0] r, input logic fl);
    for (int i = 0; i < dly; i++) begin
      cyc();
      chk("rready_wait", {31'd0, rready}, 1);
      chk("no_valid_wait", {31'd0, inst_valid}, 0);
    end
    rvalid = 1'b1; rlast = 1'b1; rdata = d; rresp = r; flush = fl; rid = $urandom;
    cyc();
    rvalid = 1'b0; rlast = 1'b0; flush = 1'b0; rdata = $urandom; rresp = $urandom;
    chk("ack_single_pulse", {31'd0, pc_ack}, 0);
    chk("rready_down", {31'd0, rready}, 0);
  endtask

  // The instruction must be presented, stay stable while decode stalls, and be released once accepted.
  task automatic expect_inst(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r, input int hold);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) cyc();
      chk("inst_valid", {31'd0, inst_valid}, 1);
      chk("if_pc", if_pc, a);
      chk("if_inst", if_inst, d);
      chk("inst_err", {31'd0, inst_err}, {31'd0, (r != 2'b00)});
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("inst_released", {31'd0, inst_valid}, 0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                       input int ad, input int rd, input int hd);
    issue(a);
    handshake(a, ad, -1);
    rbeat(rd, d, r, 1'b0);
    expect_inst(a, d, r, hd);
  endtask

  initial begin
    logic [31:0] a, d, a2, d2;
    logic [1:0]  r;
    rst = 1'b1; pc = 32'h1234_5678; pc_ce = 1'b1; flush = 1'b0; full = 1'b0;
    inst_ready = 1'b0; arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0;
    rlast = 1'b0; rvalid = 1'b0;
    cyc(); cyc();
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_rready", {31'd0, rready}, 0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 0);
    chk("rst_inst_err", {31'd0, inst_err}, 0);
    chk("rst_pc_ack", {31'd0, pc_ack}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("const_arid", {28'd0, arid}, 0);
    chk("const_arlen", {24'd0, arlen}, 0);
    chk("const_arsize", {29'd0, arsize}, 2);
    chk("const_arburst", {30'd0, arburst}, 1);
    rst = 1'b0; pc_ce = 1'b0;

    // Boot fetch with minimum latency.
    fetch(32'hBFC0_0000, 32'h2408_0001, 2'b00, 0, 0, 0);
    // Decode stalls for 4 cycles.
    fetch(32'hBFC0_0004, 32'h3C1D_8000, 2'b00, 0, 0, 4);
    // SLVERR response.
    fetch(32'hBFC0_0008, 32'hDEAD_BEEF, 2'b10, 1, 0, 0);

    // Random transactions.
    for (int n = 0; n < 20; n++) begin
      a = $urandom & 32'hFFFF_FFFC; d = $urandom; r = 2'($urandom_range(0, 3));
      fetch(a, d, r, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // Flush while the AR is stalled: the AR is held, and the returned beat is dropped.
    a = 32'h8000_1000;
    issue(a);
    handshake(a, 5, 2);
    rbeat(1, 32'h1111_1111, 2'b00, 1'b0);
    chk("flush_addr_no_valid", {31'd0, inst_valid}, 0);
    cyc();
    chk("flush_addr_idle", {31'd0, inst_valid | rready | arvalid}, 0);

    // Flush in the same cycle as the R beat.
    issue(32'h8000_2000);
    handshake(32'h8000_2000, 0, -1);
    rbeat(1, 32'h2222_2222, 2'b00, 1'b1);
    chk("flush_beat_no_valid", {31'd0, inst_valid}, 0);

    // Flush in DATA before the beat arrives. A further flush while draining is ignored.
    issue(32'h8000_3000);
    handshake(32'h8000_3000, 0, -1);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("drop_rready", {31'd0, rready}, 1);
    chk("drop_no_valid", {31'd0, inst_valid}, 0);
    rbeat(2, 32'h3333_3333, 2'b00, 1'b1);
    chk("drop_done_no_valid", {31'd0, inst_valid}, 0);

    // Flush while holding an instruction that decode has not accepted.
    a = 32'h8000_4000; d = 32'h4444_4444;
    issue(a); handshake(a, 0, -1); rbeat(0, d, 2'b00, 1'b0);
    chk("hold_valid", {31'd0, inst_valid}, 1);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("hold_flush_valid", {31'd0, inst_valid}, 0);
    chk("hold_flush_no_ar", {31'd0, arvalid}, 0);

    // A flush in IDLE suppresses the request for that cycle only.
    a = 32'h8000_5000; pc = a; pc_ce = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("idle_flush_no_ar", {31'd0, arvalid}, 0);
    cyc();
    pc_ce = 1'b0;
    chk("idle_after_flush_ar", {31'd0, arvalid}, 1);
    chk("idle_after_flush_addr", araddr, a);
    handshake(a, 0, -1); rbeat(0, 32'h5555_5555, 2'b00, 1'b0);
    expect_inst(a, 32'h5555_5555, 2'b00, 0);

    // full blocks new requests.
    a = 32'h8000_6000; pc = a; pc_ce = 1'b1; full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_no_ar", {31'd0, arvalid}, 0);
    end
    full = 1'b0;
    cyc();
    pc_ce = 1'b0;
    chk("unfull_ar", {31'd0, arvalid}, 1);
    chk("unfull_addr", araddr, a);
    handshake(a, 1, -1); rbeat(1, 32'h6666_6666, 2'b01, 1'b0);
    expect_inst(a, 32'h6666_6666, 2'b01, 0);

    // full raised mid-flight does not stop the transaction in progress.
    issue(32'h8000_7000);
    full = 1'b1;
    handshake(32'h8000_7000, 1, -1); rbeat(1, 32'h7777_7777, 2'b00, 1'b0);
    expect_inst(32'h8000_7000, 32'h7777_7777, 2'b00, 0);
    full = 1'b0;

    // Two fetches with decode always ready.
    a = 32'h9000_0000; d = 32'hAAAA_0001; a2 = 32'h9000_0004; d2 = 32'hAAAA_0002;
    issue(a); handshake(a, 0, -1); rbeat(0, d, 2'b00, 1'b0);
    chk("b2b_first_valid", {31'd0, inst_valid}, 1);
    chk("b2b_first_inst", if_inst, d);
    inst_ready = 1'b1; pc = a2; pc_ce = 1'b1;
    cyc();
    inst_ready = 1'b0;
`ifdef FETCH_BACK2BACK_EN
    pc_ce = 1'b0;
    chk("b2b_second_ar", {31'd0, arvalid}, 1);
`else
    chk("b2b_gap_no_ar", {31'd0, arvalid}, 0);
    cyc();
    pc_ce = 1'b0;
    chk("b2b_second_ar", {31'd0, arvalid}, 1);
`endif
    chk("b2b_second_addr", araddr, a2);
    handshake(a2, 0, -1); rbeat(0, d2, 2'b00, 1'b0);
    expect_inst(a2, d2, 2'b00, 0);

    // Reset during DATA abandons the read. The error fetch first makes the registered outputs nonzero.
    fetch(32'hA000_0000, 32'hBBBB_BBBB, 2'b11, 0, 0, 0);
    issue(32'hA000_0004);
    handshake(32'hA000_0004, 0, -1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_arvalid", {31'd0, arvalid}, 0);
    chk("mid_rst_rready", {31'd0, rready}, 0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 0);
    chk("mid_rst_err", {31'd0, inst_err}, 0);
    chk("mid_rst_ack", {31'd0, pc_ack}, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_if_inst", if_inst, 0);
    chk("mid_rst_if_pc", if_pc, 0);
    fetch(32'hBFC0_0000, 32'h2408_0001, 2'b00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_axi.md
INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have pc  in  32  fetch address; pc_ce  in  1  fetch enable.
REQ-004 SHALL have flush  in  1  discard fetch in progress; full  in  1  decode stage holding a saved inst, no new request.
REQ-005 SHALL have inst_ready  in  1  decode stage accepts inst.
REQ-006 SHALL have inst_valid  out  1; if_inst  out  32; if_pc  out  32; inst_err  out  1  (rresp != OKAY for this inst).
REQ-007 SHALL have pc_ack  out  1  one-cycle pulse on AR handshake; pc may advance.
REQ-008 SHALL have AXI AR: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-009 SHALL have AXI R: rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.

Function
REQ-010 SHALL drive constants arid=0, arlen=0, arsize=3'b010, arburst=2'b01 (INCR).
REQ-011 SHALL implement states IDLE, ADDR, DATA, HOLD, DROP; all outputs registered or decoded from state only.
REQ-012 IDLE: pc_ce=1, full=0, flush=0 -> latch pc into araddr and req_pc, go ADDR; else stay.
REQ-013 ADDR: arvalid=1, araddr stable until arready=1; on handshake pulse pc_ack, go DATA (DROP if flush pending).
REQ-014 SHALL NOT deassert arvalid before handshake, even on flush; flush in ADDR sets drop_pending, cleared on leaving ADDR.
REQ-015 DATA: rready=1; on rvalid&rlast: if_inst<=rdata, if_pc<=req_pc, inst_err<=(rresp!=0), go HOLD.
REQ-016 HOLD: inst_valid=1, if_inst/if_pc/inst_err stable; inst_ready=1 -> IDLE.
REQ-017 Flush in DATA: no R beat -> DROP; R beat same cycle -> discard data, go IDLE, no inst_valid.
REQ-018 Flush in HOLD: inst_valid deasserts next cycle, go IDLE regardless of inst_ready.
REQ-019 DROP: rready=1, inst_valid=0; on rvalid&rlast -> IDLE; flush ignored.
REQ-020 Flush in IDLE: no request issued that cycle.
REQ-021 Latency: pc_ce in IDLE cycle 0 -> arvalid cycle 1; arready cycle 1, rvalid cycle 2 -> inst_valid cycle 3.
REQ-022 At most one outstanding AR; rid ignored; R beats outside DATA/DROP SHALL NOT occur (no rready).
REQ-023 full=1 blocks only new requests in IDLE; transaction in flight completes.

Reset
REQ-024 rst=1 SHALL force IDLE; arvalid, rready, inst_valid, inst_err, pc_ack, drop_pending=0; araddr, if_inst, if_pc, req_pc=0.
REQ-025 Reset mid-transaction SHALL abandon it immediately; interconnect reset concurrently.

Configuration
REQ-026 FETCH_BACK2BACK_EN defined: HOLD with inst_ready=1, pc_ce=1, full=0, flush=0 SHALL latch pc and go directly to ADDR (saves one cycle).
REQ-027 FETCH_BACK2BACK_EN undefined: HOLD always returns to IDLE; next request one cycle later.

Verification
REQ-028 pc=0xBFC00000, pc_ce=1, arready=1 immediately, rvalid next cycle with rdata=0x24080001 -> pc_ack 1 pulse, inst_valid cycle 3, if_pc=0xBFC00000, if_inst=0x24080001.
REQ-029 arready held low 5 cycles, flush pulsed in cycle 2 -> arvalid held, araddr stable, after handshake rready=1, R beat discarded, inst_valid never 1.
REQ-030 HOLD with inst_ready=0 for 4 cycles -> inst_valid, if_inst, if_pc stable 4 cycles; release on inst_ready=1.
REQ-031 rresp=2'b10 on beat -> inst_valid=1 with inst_err=1.
REQ-032 full=1 in IDLE with pc_ce=1 -> no arvalid until full=0; with FETCH_BACK2BACK_EN, two fetches, inst_ready tied 1, arready/rvalid immediate -> second arvalid the cycle after first inst_valid.
REQ-033 rst=1 during DATA -> next cycle IDLE, all outputs zero.
